// File: rtl/chk_pkg.sv
// chk_pkg: shared types and default sizes for the response checker
package chk_pkg;
   typedef enum logic {ST_RUN, ST_HALT} chk_state_t;
   localparam int CHK_DEF_WIDTH = 4;
   localparam int CHK_DEF_DEPTH = 4;
endpackage

// File: rtl/chk_fifo.sv
// chk_fifo: synchronous expected-word FIFO with clear and occupancy level
module chk_fifo
   import chk_pkg::*;
#(
   parameter int WIDTH = CHK_DEF_WIDTH,
   parameter int DEPTH = CHK_DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wp;
   logic [AW:0]      r_rp;
   // Pointers carry one extra wrap bit so full and empty are distinguishable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else if (clr) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (push) r_wp <= r_wp + 1'b1;
         if (pop) r_rp <= r_rp + 1'b1;
      end
   end
   // Storage needs no reset; stale entries are never visible past the pointers
   always_ff @(posedge clk) begin
      if (push) r_mem[r_wp[AW-1:0]] <= din;
   end
   assign level = r_wp - r_rp;
   assign full  = level == FULL_LVL;
   assign empty = r_wp == r_rp;
   assign dout  = r_mem[r_rp[AW-1:0]];
endmodule

// File: rtl/resp_checker.sv
// resp_checker: compares observed DUT samples against a FIFO of expected words
module resp_checker
   import chk_pkg::*;
#(
   parameter int WIDTH       = CHK_DEF_WIDTH,
   parameter int DEPTH       = CHK_DEF_DEPTH,
   parameter int CNT_W       = 8,
   parameter bit STOP_ON_ERR = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   exp_valid,
   input  logic [WIDTH-1:0]       exp_data,
   output logic                   exp_ready,
   input  logic                   act_valid,
   input  logic [WIDTH-1:0]       act_data,
   output logic                   chk_pass,
   output logic                   chk_fail,
   output logic                   underflow,
   output logic [CNT_W-1:0]       pass_cnt,
   output logic [CNT_W-1:0]       fail_cnt,
   output logic [$clog2(DEPTH):0] level,
   output logic                   halted,
   output logic [WIDTH-1:0]       first_bad_exp,
   output logic [WIDTH-1:0]       first_bad_act
);
   chk_state_t       r_state;
   chk_state_t       w_state_nxt;
   logic             r_have_bad;
   logic [WIDTH-1:0] w_head;
   logic             w_full;
   logic             w_empty;
   logic             w_run;
   logic             w_chk;
   logic             w_push;
   logic             w_pop;
   logic             w_pass;
   logic             w_fail;
   assign w_run     = r_state == ST_RUN;
   assign exp_ready = rst_n && w_run && !w_full;
   assign halted    = r_state == ST_HALT;
   assign w_chk     = act_valid && w_run && !clr;
   assign w_push    = exp_valid && exp_ready && !clr;
   assign w_pop     = w_chk && !w_empty;
   assign w_pass    = w_pop && (act_data === w_head);
   assign w_fail    = w_chk && (w_empty || (act_data !== w_head));
   chk_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (w_push),
      .pop   (w_pop),
      .din   (exp_data),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .level (level)
   );
   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RUN;
      else r_state <= w_state_nxt;
   end
   // Clear always returns to RUN; a failure halts only when stopping is enabled
   always_comb begin
      w_state_nxt = r_state;
      if (clr) w_state_nxt = ST_RUN;
      else if (w_run && w_fail && STOP_ON_ERR) w_state_nxt = ST_HALT;
   end
   // Registered result pulses, saturating counters and first-failure capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_pass      <= 1'b0;
         chk_fail      <= 1'b0;
         underflow     <= 1'b0;
         pass_cnt      <= '0;
         fail_cnt      <= '0;
         r_have_bad    <= 1'b0;
         first_bad_exp <= '0;
         first_bad_act <= '0;
      end else if (clr) begin
         chk_pass      <= 1'b0;
         chk_fail      <= 1'b0;
         underflow     <= 1'b0;
         pass_cnt      <= '0;
         fail_cnt      <= '0;
         r_have_bad    <= 1'b0;
         first_bad_exp <= '0;
         first_bad_act <= '0;
      end else begin
         chk_pass  <= w_pass;
         chk_fail  <= w_fail;
         underflow <= w_chk && w_empty;
         if (w_pass && pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + 1'b1;
         if (w_fail && fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
         if (w_fail && !r_have_bad) begin
            r_have_bad    <= 1'b1;
            first_bad_exp <= w_empty ? '0 : w_head;
            first_bad_act <= act_data;
         end
      end
   end
endmodule

// File: tb/tb_resp_checker.sv
// tb_resp_checker: directed and randomized checks of resp_checker against a queue model
module tb_resp_checker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   logic ev = 1'b0;
   logic av = 1'b0;
   logic [3:0] ed = '0;
   logic [3:0] ad = '0;
   int n_tests = 0;
   int n_fail = 0;

   logic a_ready, a_pass, a_fail, a_under, a_halted;
   logic [7:0] a_pcnt, a_fcnt;
   logic [2:0] a_level;
   logic [3:0] a_fbe, a_fba;
   logic b_ready, b_pass, b_fail, b_under, b_halted;
   logic [1:0] b_pcnt, b_fcnt;
   logic [2:0] b_level;
   logic [3:0] b_fbe, b_fba;
   logic [31:0] a_all;
   logic [19:0] b_all;
   assign a_all = {a_pass, a_fail, a_under, a_pcnt, a_fcnt, a_level, a_halted, a_ready, a_fbe, a_fba};
   assign b_all = {b_pass, b_fail, b_under, b_pcnt, b_fcnt, b_level, b_halted, b_ready, b_fbe, b_fba};

   always #5 clk = ~clk;

   resp_checker ua (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .exp_valid(ev), .exp_data(ed), .exp_ready(a_ready),
      .act_valid(av), .act_data(ad),
      .chk_pass(a_pass), .chk_fail(a_fail), .underflow(a_under),
      .pass_cnt(a_pcnt), .fail_cnt(a_fcnt), .level(a_level), .halted(a_halted),
      .first_bad_exp(a_fbe), .first_bad_act(a_fba)
   );

   resp_checker #(.CNT_W(2), .STOP_ON_ERR(1'b0)) ub (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .exp_valid(ev), .exp_data(ed), .exp_ready(b_ready),
      .act_valid(av), .act_data(ad),
      .chk_pass(b_pass), .chk_fail(b_fail), .underflow(b_under),
      .pass_cnt(b_pcnt), .fail_cnt(b_fcnt), .level(b_level), .halted(b_halted),
      .first_bad_exp(b_fbe), .first_bad_act(b_fba)
   );

   // Reference model: one queue of expected words per instance plus scoreboard state
   logic [3:0] mq [2][$];
   bit m_p [2];
   bit m_f [2];
   bit m_u [2];
   bit m_h [2];
   bit m_have [2];
   int m_pc [2];
   int m_fc [2];
   logic [3:0] m_fbe [2];
   logic [3:0] m_fba [2];

   task automatic model_step(input int k);
      bit rdy;
      int cmax;
      logic [3:0] e;
      cmax = (k == 0) ? 255 : 3;
      rdy = !m_h[k] && mq[k].size() < 4;
      m_p[k] = 0; m_f[k] = 0; m_u[k] = 0;
      if (clr) begin
         mq[k].delete();
         m_pc[k] = 0; m_fc[k] = 0; m_h[k] = 0; m_have[k] = 0;
         m_fbe[k] = '0; m_fba[k] = '0;
      end else begin
         e = '0;
         if (av && !m_h[k]) begin
            if (mq[k].size() == 0) begin
               m_f[k] = 1; m_u[k] = 1;
            end else begin
               e = mq[k].pop_front();
               if (e == ad) m_p[k] = 1;
               else m_f[k] = 1;
            end
         end
         if (ev && rdy) mq[k].push_back(ed);
         if (m_p[k] && m_pc[k] < cmax) m_pc[k]++;
         if (m_f[k] && m_fc[k] < cmax) m_fc[k]++;
         if (m_f[k] && !m_have[k]) begin
            m_have[k] = 1; m_fbe[k] = e; m_fba[k] = ad;
         end
         if (m_f[k] && k == 0) m_h[k] = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ev = 0; av = 0; clr = 0;
   endtask

   task automatic do_clr();
      idle(); clr = 1; tick(); clr = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; idle();
      #1;
      n_tests++;
      if (a_all !== '0) begin n_fail++; $display("FAIL reset_a: got %h want 0", a_all); end
      n_tests++;
      if (b_all !== '0) begin n_fail++; $display("FAIL reset_b: got %h want 0", b_all); end
      @(negedge clk); rst_n = 1;
      tick();
      n_tests++;
      if ({a_ready, a_halted, a_level} !== {1'b1, 1'b0, 3'd0}) begin
         n_fail++; $display("FAIL reset_release: got rdy=%b halt=%b lvl=%0d want 1 0 0", a_ready, a_halted, a_level);
      end
   endtask

   task automatic test_match();
      ev = 1; ed = 4'b1011; tick();
      ed = 4'b0011; tick();
      ev = 0; av = 1; ad = 4'b1011; tick();
      n_tests++;
      if ({a_pass, a_fail} !== 2'b10) begin n_fail++; $display("FAIL match1: got p/f=%b%b want 10", a_pass, a_fail); end
      ad = 4'b0011; tick();
      n_tests++;
      if ({a_pass, a_fail} !== 2'b10) begin n_fail++; $display("FAIL match2: got p/f=%b%b want 10", a_pass, a_fail); end
      av = 0; tick();
      n_tests++;
      if ({a_pass, a_pcnt, a_level, b_pcnt} !== {1'b0, 8'd2, 3'd0, 2'd2}) begin
         n_fail++; $display("FAIL match_end: got p=%b cnt=%0d lvl=%0d bcnt=%0d want 0 2 0 2", a_pass, a_pcnt, a_level, b_pcnt);
      end
   endtask

   task automatic test_mismatch_halt();
      ev = 1; ed = 4'b1011; tick();
      ev = 0; av = 1; ad = 4'b1010; tick();
      n_tests++;
      if ({a_fail, a_pass, a_fcnt, a_fbe, a_fba, a_halted, a_ready} !== {1'b1, 1'b0, 8'd1, 4'b1011, 4'b1010, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL mismatch: got f=%b p=%b fc=%0d fbe=%b fba=%b halt=%b rdy=%b want 1 0 1 1011 1010 1 0",
            a_fail, a_pass, a_fcnt, a_fbe, a_fba, a_halted, a_ready);
      end
      ad = 4'b0110; tick();
      n_tests++;
      if ({a_fail, a_under, a_fcnt, a_halted} !== {1'b0, 1'b0, 8'd1, 1'b1}) begin
         n_fail++; $display("FAIL halt_frozen: got f=%b u=%b fc=%0d halt=%b want 0 0 1 1", a_fail, a_under, a_fcnt, a_halted);
      end
      n_tests++;
      if ({b_under, b_halted, b_fcnt} !== {1'b1, 1'b0, 2'd2}) begin
         n_fail++; $display("FAIL nostop: got u=%b halt=%b fc=%0d want 1 0 2", b_under, b_halted, b_fcnt);
      end
      do_clr();
      n_tests++;
      if ({a_halted, a_pcnt, a_fcnt, a_fbe, a_fba, a_level, a_ready} !== {1'b0, 8'd0, 8'd0, 4'd0, 4'd0, 3'd0, 1'b1}) begin
         n_fail++; $display("FAIL clr: got halt=%b pc=%0d fc=%0d fbe=%h fba=%h lvl=%0d rdy=%b want 0 0 0 0 0 0 1",
            a_halted, a_pcnt, a_fcnt, a_fbe, a_fba, a_level, a_ready);
      end
   endtask

   task automatic test_underflow();
      av = 1; ad = 4'd5; ev = 1; ed = 4'd7; tick();
      idle();
      n_tests++;
      if ({a_under, a_fail, a_fcnt, a_level, a_fbe, a_fba} !== {1'b1, 1'b1, 8'd1, 3'd1, 4'd0, 4'd5}) begin
         n_fail++; $display("FAIL underflow: got u=%b f=%b fc=%0d lvl=%0d fbe=%h fba=%h want 1 1 1 1 0 5",
            a_under, a_fail, a_fcnt, a_level, a_fbe, a_fba);
      end
      do_clr();
   endtask

   task automatic test_full();
      for (int i = 0; i < 5; i++) begin
         ev = 1; ed = 4'(i); tick();
         n_tests++;
         if (a_ready !== (i < 3)) begin n_fail++; $display("FAIL full_ready%0d: got %b want %b", i, a_ready, (i < 3)); end
      end
      ev = 0;
      n_tests++;
      if (a_level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d want 4", a_level); end
      av = 1; ad = 4'd0; tick();
      ev = 1; ed = 4'd9; ad = 4'd1; tick();
      n_tests++;
      if ({a_pass, a_level} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL pushpop: got p=%b lvl=%0d want 1 3", a_pass, a_level); end
      ev = 0;
      for (int i = 0; i < 3; i++) begin
         ad = (i == 2) ? 4'd9 : 4'(i + 2); tick();
         n_tests++;
         if (a_pass !== 1'b1) begin n_fail++; $display("FAIL drain%0d: got p=%b want 1", i, a_pass); end
      end
      idle(); tick();
      n_tests++;
      if ({a_level, a_pcnt, a_fcnt} !== {3'd0, 8'd5, 8'd0}) begin
         n_fail++; $display("FAIL full_end: got lvl=%0d pc=%0d fc=%0d want 0 5 0", a_level, a_pcnt, a_fcnt);
      end
   endtask

   task automatic test_saturate();
      logic [3:0] w;
      do_clr();
      for (int i = 0; i < 5; i++) begin
         w = 4'($urandom);
         ev = 1; ed = w; tick();
         ev = 0; av = 1; ad = w; tick();
         av = 0;
      end
      tick();
      n_tests++;
      if ({b_pcnt, b_fcnt, a_pcnt} !== {2'd3, 2'd0, 8'd5}) begin
         n_fail++; $display("FAIL saturate: got bpc=%0d bfc=%0d apc=%0d want 3 0 5", b_pcnt, b_fcnt, a_pcnt);
      end
   endtask

   task automatic test_reset_mid();
      do_clr();
      for (int i = 0; i < 3; i++) begin ev = 1; ed = 4'(i + 4); tick(); end
      ev = 0; av = 1; ad = 4'd4; tick();
      ad = 4'd5;
      #2 rst_n = 0; av = 0;
      #1;
      n_tests++;
      if (a_all !== '0 || b_all !== '0) begin n_fail++; $display("FAIL reset_mid: got a=%h b=%h want 0 0", a_all, b_all); end
      @(negedge clk); rst_n = 1;
      tick(); tick();
      n_tests++;
      if ({a_pass, a_fail, a_pcnt, a_level, a_ready} !== {1'b0, 1'b0, 8'd0, 3'd0, 1'b1}) begin
         n_fail++; $display("FAIL reset_after: got p=%b f=%b pc=%0d lvl=%0d rdy=%b want 0 0 0 0 1", a_pass, a_fail, a_pcnt, a_level, a_ready);
      end
   endtask

   task automatic test_random();
      logic [31:0] ea;
      logic [19:0] eb;
      do_clr();
      for (int k = 0; k < 2; k++) begin
         mq[k].delete();
         m_h[k] = 0; m_have[k] = 0; m_pc[k] = 0; m_fc[k] = 0;
         m_p[k] = 0; m_f[k] = 0; m_u[k] = 0; m_fbe[k] = '0; m_fba[k] = '0;
      end
      for (int c = 0; c < 400; c++) begin
         int k;
         clr = ($urandom_range(0, 39) == 0);
         ev = ($urandom_range(0, 1) == 1);
         ed = 4'($urandom);
         av = ($urandom_range(0, 9) < 4);
         k = $urandom_range(0, 1);
         ad = (mq[k].size() > 0 && $urandom_range(0, 9) < 8) ? mq[k][0] : 4'($urandom);
         model_step(0);
         model_step(1);
         tick();
         ea = {m_p[0], m_f[0], m_u[0], 8'(m_pc[0]), 8'(m_fc[0]), 3'(mq[0].size()), m_h[0],
               !m_h[0] && mq[0].size() < 4, m_fbe[0], m_fba[0]};
         eb = {m_p[1], m_f[1], m_u[1], 2'(m_pc[1]), 2'(m_fc[1]), 3'(mq[1].size()), m_h[1],
               !m_h[1] && mq[1].size() < 4, m_fbe[1], m_fba[1]};
         n_tests++;
         if (a_all !== ea) begin n_fail++; $display("FAIL rand_a cyc %0d: got %h want %h", c, a_all, ea); end
         n_tests++;
         if (b_all !== eb) begin n_fail++; $display("FAIL rand_b cyc %0d: got %h want %h", c, b_all, eb); end
      end
      idle();
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_match();
      test_mismatch_halt();
      test_underflow();
      test_full();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
